// File: rtl/hazard_unit_pkg.sv
// Shared types for hazard_unit: forward-select and FSM encodings, stage-control bundle.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_e;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD  = ctrl_t'(6'b000000);
    localparam ctrl_t CTRL_RESET = ctrl_t'(6'b001010);

    // Control for a cycle where memory is ready: a redirect beats a load-use bubble.
    function automatic ctrl_t resolve_ctrl(input logic flush, input logic load_use);
        ctrl_t c;
        if (flush)
            c = ctrl_t'(6'b111111);
        else if (load_use)
            c = ctrl_t'(6'b000111);
        else
            c = ctrl_t'(6'b110101);
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-hazard signal bundle between the datapath (master) and hazard_unit (slave).
interface hazard_unit_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  ex_dst;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  mem_dst;
    logic        mem_reg_write;
    logic [4:0]  wb_dst;
    logic        wb_reg_write;
    logic        branch_taken;
    logic        dmem_busy;
    logic [1:0]  ctrl_rs;
    logic [1:0]  ctrl_rt;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_we;
    logic        idex_flush;
    logic        exmem_we;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, ex_dst, ex_reg_write, ex_mem_read, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, branch_taken, dmem_busy,
        input  ctrl_rs, ctrl_rt, pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, ex_dst, ex_reg_write, ex_mem_read, mem_dst, mem_reg_write,
               wb_dst, wb_reg_write, branch_taken, dmem_busy,
        output ctrl_rs, ctrl_rt, pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, stall_cycles
    );
endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Operand forward select: youngest writing stage wins; register 0 never forwards.
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic [4:0] i_ex_dst,
    input  logic       i_ex_we,
    input  logic [4:0] i_mem_dst,
    input  logic       i_mem_we,
    input  logic [4:0] i_wb_dst,
    input  logic       i_wb_we,
    output fwd_e       o_sel
);
    always_comb begin
        o_sel = FWD_REG;
        if (i_src != '0) begin
            if (i_ex_we && (i_ex_dst == i_src))
                o_sel = FWD_EX;
            else if (i_mem_we && (i_mem_dst == i_src))
                o_sel = FWD_MEM;
            else if (i_wb_we && (i_wb_dst == i_src))
                o_sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush, dmem wait.
// Optional HAZARD_PERF_EN adds a free-running stall-cycle counter.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    hazard_unit_if.slave   hz
);
    state_e r_state, w_state_nxt;
    logic   r_pend_flush, w_pend_flush_nxt;
    logic   w_load_use;
    ctrl_t  w_ctrl;
    fwd_e   w_fwd_rs, w_fwd_rt;

    fwd_sel u_fwd_rs (
        .i_src(hz.id_rs), .i_ex_dst(hz.ex_dst), .i_ex_we(hz.ex_reg_write),
        .i_mem_dst(hz.mem_dst), .i_mem_we(hz.mem_reg_write),
        .i_wb_dst(hz.wb_dst), .i_wb_we(hz.wb_reg_write), .o_sel(w_fwd_rs)
    );

    fwd_sel u_fwd_rt (
        .i_src(hz.id_rt), .i_ex_dst(hz.ex_dst), .i_ex_we(hz.ex_reg_write),
        .i_mem_dst(hz.mem_dst), .i_mem_we(hz.mem_reg_write),
        .i_wb_dst(hz.wb_dst), .i_wb_we(hz.wb_reg_write), .o_sel(w_fwd_rt)
    );

    assign hz.ctrl_rs = w_fwd_rs;
    assign hz.ctrl_rt = w_fwd_rt;

    assign w_load_use = hz.ex_mem_read && (hz.ex_dst != '0) &&
                        ((hz.ex_dst == hz.id_rs) || (hz.ex_dst == hz.id_rt));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_pend_flush <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_flush <= w_pend_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pend_flush_nxt = r_pend_flush;
        w_ctrl           = CTRL_HOLD;
        if (!reset) begin
            w_ctrl = CTRL_RESET;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (hz.dmem_busy) begin
                        w_pend_flush_nxt = hz.branch_taken;
                        w_state_nxt      = MEM_WAIT;
                    end else begin
                        w_ctrl = resolve_ctrl(hz.branch_taken, w_load_use);
                    end
                end
                MEM_WAIT: begin
                    if (hz.dmem_busy) begin
                        w_pend_flush_nxt = r_pend_flush | hz.branch_taken;
                    end else begin
                        // A redirect seen while memory stalled is applied on release.
                        w_ctrl           = resolve_ctrl(r_pend_flush | hz.branch_taken, w_load_use);
                        w_pend_flush_nxt = 1'b0;
                        w_state_nxt      = RUN;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    assign hz.pc_we      = w_ctrl.pc_we;
    assign hz.ifid_we    = w_ctrl.ifid_we;
    assign hz.ifid_flush = w_ctrl.ifid_flush;
    assign hz.idex_we    = w_ctrl.idex_we;
    assign hz.idex_flush = w_ctrl.idex_flush;
    assign hz.exmem_we   = w_ctrl.exmem_we;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_stall_cycles <= '0;
        else if (!w_ctrl.pc_we)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

    assign hz.stall_cycles = r_stall_cycles;
`else
    assign hz.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios then randomized cycles vs a reference model.
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_if hz();

    hazard_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.slave)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: "waiting on memory" flag, remembered redirect, stall tally.
    bit          m_wait;
    bit          m_pend;
    logic [31:0] m_stalls;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (hz.ex_reg_write  && hz.ex_dst  == src) return 2'd1;
        if (hz.mem_reg_write && hz.mem_dst == src) return 2'd2;
        if (hz.wb_reg_write  && hz.wb_dst  == src) return 2'd3;
        return 2'd0;
    endfunction

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we}
    function automatic logic [5:0] m_ctl();
        bit lu;
        lu = hz.ex_mem_read && hz.ex_dst != 5'd0 &&
             (hz.ex_dst == hz.id_rs || hz.ex_dst == hz.id_rt);
        if (!reset)                         return 6'b001010;
        if (hz.dmem_busy)                   return 6'b000000;
        if (hz.branch_taken || (m_wait && m_pend)) return 6'b111111;
        if (lu)                             return 6'b000111;
        return 6'b110101;
    endfunction

    function automatic logic [5:0] dut_ctl();
        return {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush, hz.exmem_we};
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".rs"},    {30'd0, hz.ctrl_rs}, {30'd0, m_fwd(hz.id_rs)});
        check({tag, ".rt"},    {30'd0, hz.ctrl_rt}, {30'd0, m_fwd(hz.id_rt)});
        check({tag, ".ctl"},   {26'd0, dut_ctl()},  {26'd0, m_ctl()});
        check({tag, ".stall"}, hz.stall_cycles,     m_stalls);
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (!v) begin
            m_wait   = 1'b0;
            m_pend   = 1'b0;
            m_stalls = '0;
        end
        #1;
    endtask

    // Advance one clock; model state updates from the inputs held across the edge.
    task automatic tick();
        logic [5:0] c;
        c = m_ctl();
        @(posedge clk);
        if (reset) begin
`ifdef HAZARD_PERF_EN
            if (!c[5]) m_stalls = m_stalls + 32'd1;
`endif
            if (!m_wait) begin
                if (hz.dmem_busy) begin
                    m_wait = 1'b1;
                    m_pend = hz.branch_taken;
                end
            end else if (hz.dmem_busy) begin
                m_pend = m_pend | hz.branch_taken;
            end else begin
                m_wait = 1'b0;
                m_pend = 1'b0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs = '0; hz.id_rt = '0; hz.ex_dst = '0; hz.ex_reg_write = 1'b0;
        hz.ex_mem_read = 1'b0; hz.mem_dst = '0; hz.mem_reg_write = 1'b0;
        hz.wb_dst = '0; hz.wb_reg_write = 1'b0; hz.branch_taken = 1'b0; hz.dmem_busy = 1'b0;
    endtask

    initial begin
        clear_inputs();
        set_reset(1'b0);
        check_all("reset");
        check("reset.ctl_const", {26'd0, dut_ctl()}, 32'h0A);
        tick();
        tick();
        set_reset(1'b1);
        check_all("idle");

        // Youngest producer wins; dropping EX write falls back to MEM.
        hz.id_rs = 5'd5; hz.ex_dst = 5'd5; hz.ex_reg_write = 1'b1;
        hz.mem_dst = 5'd5; hz.mem_reg_write = 1'b1;
        #1;
        check("fwd_ex", {30'd0, hz.ctrl_rs}, 32'd1);
        hz.ex_reg_write = 1'b0;
        #1;
        check("fwd_mem", {30'd0, hz.ctrl_rs}, 32'd2);
        check_all("fwd_mem");

        // Register 0 never forwards.
        clear_inputs();
        hz.id_rt = 5'd0; hz.wb_dst = 5'd0; hz.wb_reg_write = 1'b1;
        #1;
        check("fwd_r0", {30'd0, hz.ctrl_rt}, 32'd0);
        tick();

        // Single-cycle load-use bubble.
        clear_inputs();
        hz.ex_mem_read = 1'b1; hz.ex_dst = 5'd8; hz.id_rt = 5'd8;
        #1;
        check("loaduse.ctl", {26'd0, dut_ctl()}, 32'h07);
        check_all("loaduse");
        tick();
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_EN
        check("loaduse.stall", hz.stall_cycles, 32'd1);
`else
        check("loaduse.stall", hz.stall_cycles, 32'd0);
`endif
        check_all("after_lu");

        // Three busy cycles with a redirect in the second; flush on release.
        for (int i = 0; i < 3; i++) begin
            hz.dmem_busy = 1'b1;
            hz.branch_taken = (i == 1);
            #1;
            check("busy.ctl", {26'd0, dut_ctl()}, 32'h00);
            check_all("busy");
            tick();
        end
        clear_inputs();
        #1;
        check("release.ctl", {26'd0, dut_ctl()}, 32'h3F);
        check_all("release");
        tick();
        check_all("back_run");

        // Redirect beats a simultaneous load-use.
        hz.branch_taken = 1'b1; hz.ex_mem_read = 1'b1; hz.ex_dst = 5'd3; hz.id_rs = 5'd3;
        #1;
        check("br_vs_lu.ctl", {26'd0, dut_ctl()}, 32'h3F);
        tick();

        // Reset in MEM_WAIT with a pending flush discards it.
        clear_inputs();
        hz.dmem_busy = 1'b1;
        tick();
        hz.branch_taken = 1'b1;
        tick();
        set_reset(1'b0);
        check("rst_wait.ctl", {26'd0, dut_ctl()}, 32'h0A);
        check_all("rst_wait");
        tick();
        clear_inputs();
        set_reset(1'b1);
        check("rst_rel.ctl", {26'd0, dut_ctl()}, 32'h35);
        check("rst_rel.stall", hz.stall_cycles, 32'd0);
        check_all("rst_rel");

        // Randomized cycles with clustered register numbers so matches are common.
        for (int n = 0; n < 3000; n++) begin
            hz.id_rs         = 5'($urandom_range(0, 6));
            hz.id_rt         = 5'($urandom_range(0, 6));
            hz.ex_dst        = 5'($urandom_range(0, 6));
            hz.mem_dst       = 5'($urandom_range(0, 6));
            hz.wb_dst        = 5'($urandom_range(0, 6));
            hz.ex_reg_write  = 1'($urandom);
            hz.ex_mem_read   = ($urandom_range(0, 2) == 0);
            hz.mem_reg_write = 1'($urandom);
            hz.wb_reg_write  = 1'($urandom);
            hz.branch_taken  = ($urandom_range(0, 4) == 0);
            hz.dmem_busy     = ($urandom_range(0, 3) == 0);
            set_reset($urandom_range(0, 63) != 0);
            check_all("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock (rising edge); reset  in  1  asynchronous active-low reset (0 = reset).
REQ-002 SHALL have inputs: id_rs  in  5  ID rs field; id_rt  in  5  ID rt field; ex_dst  in  5  EX dest reg; ex_reg_write  in  1; ex_mem_read  in  1  EX holds load; mem_dst  in  5; mem_reg_write  in  1; wb_dst  in  5; wb_reg_write  in  1; branch_taken  in  1  redirect resolved; dmem_busy  in  1  data memory not ready.
REQ-003 SHALL have outputs: ctrl_rs  out  2  rs forward select (0 regfile, 1 ex, 2 mem, 3 wb); ctrl_rt  out  2  rt forward select, same encoding; pc_we  out  1; ifid_we  out  1; ifid_flush  out  1; idex_we  out  1; idex_flush  out  1; exmem_we  out  1; stall_cycles  out  32  stall counter.

Function
REQ-004 ctrl_rs SHALL be combinational: 1 if ex_reg_write and ex_dst==id_rs; else 2 if mem_reg_write and mem_dst==id_rs; else 3 if wb_reg_write and wb_dst==id_rs; else 0.
REQ-005 ctrl_rt SHALL follow REQ-004 using id_rt.
REQ-006 A dest of 0 SHALL never match (ctrl = 0 for register 0).
REQ-007 load_use SHALL be ex_mem_read and ex_dst!=0 and (ex_dst==id_rs or ex_dst==id_rt).
REQ-008 FSM states SHALL be RUN and MEM_WAIT, plus a pend_flush flag.
REQ-009 RUN, dmem_busy=1: all *_we=0, flushes 0; if branch_taken, set pend_flush; next MEM_WAIT.
REQ-010 RUN, dmem_busy=0, branch_taken=1: all *_we=1, ifid_flush=1, idex_flush=1; branch beats load_use.
REQ-011 RUN, dmem_busy=0, no branch, load_use=1: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1, exmem_we=1.
REQ-012 RUN, no event: all *_we=1, flushes 0.
REQ-013 MEM_WAIT, dmem_busy=1: all *_we=0, flushes 0; branch_taken SHALL set pend_flush.
REQ-014 MEM_WAIT, dmem_busy=0: apply REQ-010 if pend_flush or branch_taken, else REQ-011/REQ-012; clear pend_flush; next RUN.
REQ-015 Forwarding outputs SHALL be valid in every state, independent of stalls.
REQ-016 Enable and flush outputs SHALL be combinational from state, pend_flush and inputs; zero-cycle latency.

Reset
REQ-017 On reset=0, asynchronously: state=RUN, pend_flush=0, stall_cycles=0.
REQ-018 While reset=0: all *_we=0, ifid_flush=1, idex_flush=1; ctrl_rs/ctrl_rt per REQ-004.
REQ-019 Reset asserted in MEM_WAIT SHALL discard pend_flush; first cycle after release SHALL be RUN.

Configuration
REQ-020 With HAZARD_PERF_EN defined, stall_cycles SHALL increment by 1 on each clock where pc_we=0 and reset=1, wrapping 0xFFFFFFFF->0.
REQ-021 Without HAZARD_PERF_EN, stall_cycles SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-022 Shared package SHALL hold forward-select encodings (FWD_REG=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3) and state encodings (RUN, MEM_WAIT).
REQ-023 One sub-module, fwd_sel, SHALL implement REQ-004/REQ-006, instantiated twice (rs, rt).

Verification
REQ-024 id_rs=5, ex_dst=5, ex_reg_write=1, mem_dst=5, mem_reg_write=1 -> ctrl_rs=1; clear ex_reg_write -> ctrl_rs=2.
REQ-025 id_rt=0, wb_dst=0, wb_reg_write=1 -> ctrl_rt=0.
REQ-026 ex_mem_read=1, ex_dst=8, id_rt=8 for one cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle; stall_cycles=1 (perf build).
REQ-027 dmem_busy=1 for 3 cycles, branch_taken pulsed in 2nd -> all *_we=0 for 3 cycles; on 4th cycle ifid_flush=1, idex_flush=1, all *_we=1, state RUN.
REQ-028 branch_taken=1 with load_use=1, dmem_busy=0 -> pc_we=1, ifid_flush=1, idex_flush=1.
REQ-029 reset low mid-MEM_WAIT with pend_flush=1, then release, dmem_busy=0 -> flushes 0, all *_we=1, stall_cycles=0.
